mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, number of extra access cycles inserted per request (range 0..15; used only when MEM_WAIT_STATES_EN is defined).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  1  initiator presents a memory request.
REQ-005 req_ready  output  1  responder can accept a request this cycle.
REQ-006 req_we  input  1  1 = write, 0 = read.
REQ-007 req_addr  input  8  word address (MAR value).
REQ-008 req_wdata  input  16  write data (MDR value).
REQ-009 rsp_valid  output  1  response available.
REQ-010 rsp_ready  input  1  initiator accepts the response.
REQ-011 rsp_rdata  output  16  read data; write data echoed for writes.
REQ-012 rsp_we  output  1  copy of captured req_we for the current response.

Function
REQ-013 The block SHALL hold a 256 x 16 single-port word memory, addresses 0x00..0xFF, all addresses valid, no wrap or aliasing.
REQ-014 The FSM SHALL have states IDLE, WAIT, ACCESS, RESP.
REQ-015 IDLE: req_ready=1; on req_valid&&req_ready, capture req_we/req_addr/req_wdata, then go to WAIT if MEM_WAIT_STATES_EN is defined and WAIT_CYCLES>0, else go to ACCESS.
REQ-016 WAIT: req_ready=0; a 4-bit counter loaded with WAIT_CYCLES-1 on entry decrements each cycle; at 0 go to ACCESS.
REQ-017 ACCESS: req_ready=0; at the closing edge, perform the array write (we=1) or read (we=0) at the captured address, register rsp_rdata (read word, or captured wdata for writes), then go to RESP.
REQ-018 RESP: rsp_valid=1; rsp_rdata and rsp_we held stable until rsp_valid&&rsp_ready, then go to IDLE.
REQ-019 Latency without wait states SHALL be: request accepted at edge N, rsp_valid high after edge N+1; with wait states, after edge N+1+WAIT_CYCLES.
REQ-020 req_ready SHALL be 1 only in IDLE; a request is never accepted in the same cycle as a response handshake, so the earliest next acceptance is one cycle after the rsp handshake.
REQ-021 Inputs SHALL be ignored outside the acceptance cycle; changes to req_* after acceptance do not affect the operation in flight.
REQ-022 A read following a write to the same address SHALL return the newly written data.

Reset
REQ-023 On rst assertion the block SHALL go immediately to IDLE with req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_we=0, and the wait counter at 0.
REQ-024 A reset asserted in WAIT, or before the ACCESS edge, SHALL discard the pending operation; the memory SHALL not be written.
REQ-025 Memory contents SHALL not be cleared by rst; contents after power-up are undefined.

Configuration
REQ-026 Macro MEM_WAIT_STATES_EN: when defined, the WAIT state and counter SHALL be compiled in and honour WAIT_CYCLES; when undefined, they SHALL be absent, WAIT_CYCLES SHALL be ignored, and latency SHALL be fixed per REQ-019 with no wait states.

Structure
REQ-027 The shared package mem_pkg SHALL define ADDR_W=8, DATA_W=16, DEPTH=256 and the FSM state enum (IDLE, WAIT, ACCESS, RESP).
REQ-028 The storage SHALL be a sub-module mem_array: a synchronous single-port 256x16 array with we, addr, wdata and registered rdata.

Verification
REQ-029 The bench SHALL cover: write 0xBEEF to 0x10, then read 0x10 (no macro) -> rsp_valid one cycle after each acceptance, read rsp_rdata=0xBEEF, rsp_we=0.
REQ-030 The bench SHALL cover: MEM_WAIT_STATES_EN with WAIT_CYCLES=3, read 0x00 -> rsp_valid exactly 4 cycles after acceptance, and req_ready=0 throughout.
REQ-031 The bench SHALL cover: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stable, and req_valid ignored; after rsp_ready=1, req_ready=1 on the next cycle.
REQ-032 The bench SHALL cover: write 0x1234 to 0xFF, write 0x5678 to 0x00, read 0xFF -> returns 0x1234 (no wrap).
REQ-033 The bench SHALL cover: preload 0x20=0xAAAA, then a write of 0x5555 to 0x20 with rst pulsed in WAIT -> all outputs reset values immediately, and a later read of 0x20 returns 0xAAAA.
REQ-034 The bench SHALL cover: change req_addr/req_wdata the cycle after acceptance -> the operation uses the captured values.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: widths, depth, FSM states.
// Imported by mem_array and mem_responder.
package mem_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 256;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    RESP
  } state_t;
endpackage

// File: rtl/mem_array.sv
// Synchronous single-port 256x16 word store, registered read data.
// Ports: clk, we, addr, wdata in; rdata out. Contents have no reset.
module mem_array
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Request/response front end for a 256x16 memory with optional waits.
// Ports: clk, rst (async high), req_* handshake in, rsp_* handshake out.
// Macro MEM_WAIT_STATES_EN compiles in the WAIT state and its counter.
module mem_responder
  import mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_we
);

  state_t state;
  state_t next;

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic              accept;

  assign accept = (state == IDLE) && req_valid;

`ifdef MEM_WAIT_STATES_EN
  localparam bit USE_WAIT = (WAIT_CYCLES > 0);

  logic [3:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (accept) begin
      cnt <= USE_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;
    end else if (state == WAIT && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end
`else
  localparam bit USE_WAIT = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE:   if (req_valid) next = USE_WAIT ? WAIT : ACCESS;
`ifdef MEM_WAIT_STATES_EN
      WAIT:   if (cnt == 4'd0) next = ACCESS;
`endif
      ACCESS: next = RESP;
      RESP:   if (rsp_ready) next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_we    = 1'b0;
    unique case (state)
      IDLE:   req_ready = 1'b1;
      ACCESS: mem_we    = we_q;
      RESP:   rsp_valid = 1'b1;
      default: ;
    endcase
    // Array output is the word read at the ACCESS edge; addr_q is
    // frozen through RESP so it keeps re-reading the same word.
    rsp_rdata = '0;
    if (rsp_valid) rsp_rdata = we_q ? wdata_q : mem_rdata;
    rsp_we = rsp_valid & we_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  mem_array u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

endmodule
